// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : WISC pipeline hazard unit. Tracks in-flight instructions in a
//               shift-register scoreboard. Detects register RAW, flag RAW and
//               BR rs hazards, drives the PC and IF/ID write enables and the
//               ID/EX bubble, squashes wrong-path fetches after a taken
//               branch, and keeps a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_BITS     = 4,
  parameter int DEPTH        = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FWD_EN       = 1,
  parameter int FLAG_READY   = 1,
  parameter int BR_READY     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic [2:0]          id_flag_en,
  input  logic                branch,
  input  logic                branchr,
  input  logic [2:0]          condition,
  input  logic                branch_taken,
  output logic                pc_wen,
  output logic                if_id_wen,
  output logic                id_ex_bubble,
  output logic                if_id_flush,
  output logic [2:0]          hazard_cause,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam bit         NO_FWD     = (FWD_EN == 0);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;

  // Scoreboard storage: index 0 is the youngest (EX) entry
  logic [DEPTH-1:0]    sb_valid;
  logic [DEPTH-1:0]    sb_wr;
  logic [DEPTH-1:0]    sb_ld;
  logic [REG_BITS-1:0] sb_rd   [DEPTH];
  logic [2:0]          sb_flag [DEPTH];

  logic [DEPTH-1:0] raw_vec;
  logic [DEPTH-1:0] flag_vec;
  logic [DEPTH-1:0] br_vec;
  logic [2:0]       need;
  logic             id_live;
  logic             raw_hit;
  logic             flag_hit;
  logic             br_hit;
  logic             stall;
  logic             push;

  // Flags each branch condition reads ([2]=Z, [1]=V, [0]=N)
  always_comb begin
    need = 3'b000;
    case (condition)
      3'b000, 3'b001: need = 3'b100;
      3'b010:         need = 3'b101;
      3'b011:         need = 3'b001;
      3'b100, 3'b101: need = 3'b101;
      3'b110:         need = 3'b010;
      default:        need = 3'b000;
    endcase
  end

  // Per-entry hazard terms; readiness thresholds are fixed per index
  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    localparam bit LD_EARLY = (k < LOAD_LAT);
    localparam bit FL_EARLY = (k < FLAG_READY);
    localparam bit BR_EARLY = (k < BR_READY);
    logic writer;
    logic src_hit;
    assign writer      = sb_valid[k] & sb_wr[k] & (sb_rd[k] != '0);
    assign src_hit     = (id_rs_used & (sb_rd[k] == id_rs)) |
                         (id_rt_used & (sb_rd[k] == id_rt));
    assign raw_vec[k]  = writer & src_hit & ((sb_ld[k] & LD_EARLY) | NO_FWD);
    assign flag_vec[k] = sb_valid[k] & ((sb_flag[k] & need) != 3'b000) & FL_EARLY;
    assign br_vec[k]   = writer & (sb_rd[k] == id_rs) & BR_EARLY;
  end

  // A flushed ID slot is a wrong-path fetch: it never stalls and is never pushed
  assign id_live  = id_valid & ~if_id_flush;
  assign raw_hit  = |raw_vec;
  assign flag_hit = (branch | branchr) & (condition != 3'b111) & (|flag_vec);
  assign br_hit   = branchr & (id_rs != '0) & (|br_vec);
  assign stall    = id_live & (raw_hit | flag_hit | br_hit);
  assign push     = id_live & ~stall;

  assign pc_wen       = ~stall;
  assign if_id_wen    = ~stall;
  assign id_ex_bubble = stall | if_id_flush;
  assign if_id_flush  = (state == FLUSH);
  assign hazard_cause = {3{id_live}} & {br_hit, flag_hit, raw_hit};

  // Scoreboard shift: entries age by one slot per cycle, oldest retires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid <= '0;
      sb_wr    <= '0;
      sb_ld    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        sb_rd[k]   <= '0;
        sb_flag[k] <= '0;
      end
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_wr[k]    <= sb_wr[k-1];
        sb_ld[k]    <= sb_ld[k-1];
        sb_rd[k]    <= sb_rd[k-1];
        sb_flag[k]  <= sb_flag[k-1];
      end
      sb_valid[0] <= push;
      sb_wr[0]    <= id_reg_write;
      sb_ld[0]    <= id_mem_read;
      sb_rd[0]    <= id_rd;
      sb_flag[0]  <= id_flag_en;
    end
  end

  // Flush FSM state and down-counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Flush FSM next state: a taken branch is honoured only once it issues
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      RUN: begin
        if (branch_taken & id_valid & ~stall) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (flush_cnt <= 3'd1) begin
          state_nxt     = RUN;
          flush_cnt_nxt = 3'd0;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
        end
      end
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Saturating stall-cycle counter for performance debug
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
